alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 120 ++++++++++++
 tb/tb_alu_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational 8-bit ALU.
// Optional illegal-opcode checking is enabled by defining ALU_ARB_OPCHECK_EN.
module alu_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [3:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req1_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_overflow,
  output logic       rsp_zero,
  output logic       rsp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   grant;
  logic   accept;
  logic   op_illegal;

  // Tie goes to whichever requester was not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  // Readies are masked during reset, since the async reset already holds IDLE.
  assign accept     = (state == IDLE) && !rst && (grant ? req1_valid : req0_valid);
  assign req0_ready = accept && !grant;
  assign req1_ready = accept && grant;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block is given a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    rsp_valid = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = EXEC;
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/opcode registers and the requester id change only on an accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      rsp_id     <= 1'b0;
    end else if (accept) begin
      last_grant <= grant;
      rsp_id     <= grant;
      alu_a      <= grant ? req1_a  : req0_a;
      alu_b      <= grant ? req1_b  : req0_b;
      alu_opcode <= grant ? req1_op : req0_op;
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  assign op_illegal = (alu_opcode > 4'd8);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 rsp_err <= 1'b0;
    else if (state == EXEC)  rsp_err <= op_illegal;
  end
`else
  assign op_illegal = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  // Result is captured at the end of EXEC and held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data     <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
    end else if (state == EXEC) begin
      rsp_data     <= op_illegal ? 8'h00 : alu_out;
      rsp_carry    <= alu_carry    && !op_illegal;
      rsp_overflow <= alu_overflow && !op_illegal;
      rsp_zero     <= alu_zero     && !op_illegal;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small reference 8-bit ALU attached.
// Expected rsp_err/rsp_data for illegal opcodes follow ALU_ARB_OPCHECK_EN.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_op, req1_op;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_opcode;
  logic [7:0] alu_out;
  logic       alu_carry, alu_overflow, alu_zero;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_carry, rsp_overflow, rsp_zero, rsp_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [13:0] rsp_bus;
  logic [19:0] alu_bus;
  assign rsp_bus = {rsp_valid, rsp_id, rsp_err, rsp_carry, rsp_overflow, rsp_zero, rsp_data};
  assign alu_bus = {alu_a, alu_b, alu_opcode};

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry),
    .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  // Reference ALU: 0 add, 1 sub (carry = borrow), 2 and, 3 or, 4 xor,
  // 5 not a, 6 shl a, 7 shr a, 8 pass b; opcodes above 8 pass a through.
  always_comb begin
    alu_out      = 8'h00;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    case (alu_opcode)
      4'd0: begin
        {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);
      end
      4'd1: begin
        alu_out      = alu_a - alu_b;
        alu_carry    = alu_a < alu_b;
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_out[7] != alu_a[7]);
      end
      4'd2: alu_out = alu_a & alu_b;
      4'd3: alu_out = alu_a | alu_b;
      4'd4: alu_out = alu_a ^ alu_b;
      4'd5: alu_out = ~alu_a;
      4'd6: {alu_carry, alu_out} = {alu_a, 1'b0};
      4'd7: {alu_out, alu_carry} = {1'b0, alu_a};
      4'd8: alu_out = alu_b;
      default: alu_out = alu_a;
    endcase
    alu_zero = (alu_out == 8'h00);
  end

  function automatic logic [13:0] pack(input logic v, input logic id, input logic err,
                                       input logic c, input logic o, input logic z,
                                       input logic [7:0] d);
    return {v, id, err, c, o, z, d};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h05; req0_op = 4'd1;
    req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01; req1_op = 4'd0;
    repeat (2) step();
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    n_checks++;
    if (alu_bus !== 20'h0) begin
      n_fail++; $display("FAIL reset_alu got=%h exp=00000", alu_bus);
    end
    n_checks++;
    if (rsp_bus !== 14'h0) begin
      n_fail++; $display("FAIL reset_rsp got=%h exp=0000", rsp_bus);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_tie();
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL tie_first_ready got=%b exp=10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    #1;
    n_checks++;
    if (alu_bus !== {8'h05, 8'h05, 4'd1}) begin
      n_fail++; $display("FAIL tie_alu_load got=%h exp=%h", alu_bus, {8'h05, 8'h05, 4'd1});
    end
    n_checks++;
    if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL tie_exec_quiet got=%b exp=000", {req0_ready, req1_ready, rsp_valid});
    end
    step();
    n_checks++;
    if (rsp_bus !== pack(1, 0, 0, 0, 0, 1, 8'h00)) begin
      n_fail++; $display("FAIL tie_rsp0 got=%h exp=%h", rsp_bus, pack(1, 0, 0, 0, 0, 1, 8'h00));
    end
    step();
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL tie_second_ready got=%b exp=01", {req0_ready, req1_ready});
    end
    step();
    req1_valid = 1'b0;
    step();
    n_checks++;
    if (rsp_bus !== pack(1, 1, 0, 1, 0, 1, 8'h00)) begin
      n_fail++; $display("FAIL tie_rsp1 got=%h exp=%h", rsp_bus, pack(1, 1, 0, 1, 0, 1, 8'h00));
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL tie_rsp_drop got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_a = 8'h7F; req0_b = 8'h01; req0_op = 4'd0;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL single_ready got=%b exp=10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    #1;
    n_checks++;
    if ({rsp_valid, alu_bus} !== {1'b0, 8'h7F, 8'h01, 4'd0}) begin
      n_fail++; $display("FAIL single_exec got=%h exp=%h", {rsp_valid, alu_bus}, {1'b0, 8'h7F, 8'h01, 4'd0});
    end
    step();
    n_checks++;
    if (rsp_bus !== pack(1, 0, 0, 0, 1, 0, 8'h80)) begin
      n_fail++; $display("FAIL single_rsp got=%h exp=%h", rsp_bus, pack(1, 0, 0, 0, 1, 0, 8'h80));
    end
    step();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL single_rsp_drop got=%b exp=0", rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] exp_rsp;
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h3C; req1_b = 8'h0F; req1_op = 4'd2;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_ready1 got=%b exp=01", {req0_ready, req1_ready});
    end
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'hF0; req0_b = 8'h0F; req0_op = 4'd3;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      n_fail++; $display("FAIL bp_exec_ready got=%b exp=00", {req0_ready, req1_ready});
    end
    step();
    exp_rsp = pack(1, 1, 0, 0, 0, 0, 8'h0C);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rsp_bus, req0_ready, req1_ready} !== {exp_rsp, 2'b00}) begin
        n_fail++; $display("FAIL bp_hold[%0d] got=%h exp=%h", i, {rsp_bus, req0_ready, req1_ready}, {exp_rsp, 2'b00});
      end
      step();
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++;
    if (rsp_bus !== exp_rsp) begin
      n_fail++; $display("FAIL bp_release got=%h exp=%h", rsp_bus, exp_rsp);
    end
    step();
    n_checks++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b010) begin
      n_fail++; $display("FAIL bp_idle got=%b exp=010", {rsp_valid, req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    step();
    n_checks++;
    if (rsp_bus !== pack(1, 0, 0, 0, 0, 0, 8'hFF)) begin
      n_fail++; $display("FAIL bp_waiter_rsp got=%h exp=%h", rsp_bus, pack(1, 0, 0, 0, 0, 0, 8'hFF));
    end
    step();
  endtask

  task automatic test_reset_mid_exec();
    req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h55; req1_op = 4'd4;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL rx_ready got=%b exp=01", {req0_ready, req1_ready});
    end
    step();
    req1_valid = 1'b0;
    n_checks++;
    if (alu_bus !== {8'hAA, 8'h55, 4'd4}) begin
      n_fail++; $display("FAIL rx_alu_load got=%h exp=%h", alu_bus, {8'hAA, 8'h55, 4'd4});
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({alu_bus, rsp_bus} !== 34'h0) begin
      n_fail++; $display("FAIL rx_async_clear got=%h exp=0", {alu_bus, rsp_bus});
    end
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL rx_no_rsp[%0d] got=%b exp=0", i, rsp_valid);
      end
    end
  endtask

  task automatic test_fairness();
    logic exp_id;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h01; req0_op = 4'd0;
    req1_valid = 1'b1; req1_a = 8'h20; req1_b = 8'h02; req1_op = 4'd1;
    for (int k = 0; k < 6; k++) begin
      exp_id = (k % 2 == 1);
      #1;
      n_checks++;
      if ({req0_ready, req1_ready} !== (exp_id ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL fair_grant[%0d] got=%b exp=%b", k, {req0_ready, req1_ready}, exp_id ? 2'b01 : 2'b10);
      end
      step();
      step();
      n_checks++;
      if (rsp_bus !== pack(1, exp_id, 0, 0, 0, 0, exp_id ? 8'h1E : 8'h11)) begin
        n_fail++; $display("FAIL fair_rsp[%0d] got=%h exp=%h", k, rsp_bus, pack(1, exp_id, 0, 0, 0, 0, exp_id ? 8'h1E : 8'h11));
      end
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_opcheck();
    logic [13:0] exp_rsp;
`ifdef ALU_ARB_OPCHECK_EN
    exp_rsp = pack(1, 0, 1, 0, 0, 0, 8'h00);
`else
    exp_rsp = pack(1, 0, 0, 0, 0, 0, 8'h5A);
`endif
    req0_valid = 1'b1; req0_a = 8'h5A; req0_b = 8'h11; req0_op = 4'hC;
    step();
    req0_valid = 1'b0;
    step();
    n_checks++;
    if (rsp_bus !== exp_rsp) begin
      n_fail++; $display("FAIL opcheck_illegal got=%h exp=%h", rsp_bus, exp_rsp);
    end
    step();
    req0_valid = 1'b1; req0_op = 4'd8;
    step();
    req0_valid = 1'b0;
    step();
    n_checks++;
    if (rsp_bus !== pack(1, 0, 0, 0, 0, 0, 8'h11)) begin
      n_fail++; $display("FAIL opcheck_legal8 got=%h exp=%h", rsp_bus, pack(1, 0, 0, 0, 0, 0, 8'h11));
    end
    step();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_backpressure();
    test_reset_mid_exec();
    test_fairness();
    test_opcheck();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
